// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C request arbiter: FSM states and the latched command payload.
package i2c_arb_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} arb_state_e;

  typedef struct packed {
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } i2c_cmd_t;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping at NREQ.
module i2c_rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j[IDX_W-1:0]]) begin
        any                 = 1'b1;
        grant[j[IDX_W-1:0]] = 1'b1;
        idx                 = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin sharing of one I2C master among NREQ requesters, with timeout abort.
// Optional single retry on ack error when I2C_ARB_RETRY_EN is defined.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_op,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_din,
  output logic [NREQ-1:0]          req_ack,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]        rsp_dout,
  output logic                     rsp_err,
  output logic                     rsp_timeout,
  output logic                     m_newd,
  output logic                     m_op,
  output logic [ADDR_W-1:0]        m_addr,
  output logic [DATA_W-1:0]        m_din,
  input  logic [DATA_W-1:0]        m_dout,
  input  logic                     m_busy,
  input  logic                     m_ack_err,
  input  logic                     m_done
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT);

`ifdef I2C_ARB_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  arb_state_e       state;
  i2c_cmd_t         cmd;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] cnt;
  logic             err_q;
  logic             retried;

  logic [NREQ-1:0]  grant;
  logic [ID_W-1:0]  win_idx;
  logic             win_any;
  int unsigned      sel;
  logic             done_err;
  logic             retry_now;

  i2c_rr_pick #(.NREQ(NREQ), .IDX_W(ID_W)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign sel       = 32'(win_idx);
  assign done_err  = err_q | m_ack_err;
  assign retry_now = RETRY_EN && done_err && !retried;

  assign m_op   = cmd.op;
  assign m_addr = cmd.addr;
  assign m_din  = cmd.din;

  // cnt holds the number of cycles elapsed since the newd cycle (0 during ISSUE).
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd         <= '0;
      id_q        <= '0;
      ptr         <= '0;
      cnt         <= '0;
      err_q       <= 1'b0;
      retried     <= 1'b0;
      req_ack     <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_dout    <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      m_newd      <= 1'b0;
    end else begin
      req_ack   <= '0;
      rsp_valid <= 1'b0;
      m_newd    <= 1'b0;
      case (state)
        IDLE: begin
          if (win_any && !m_busy) begin
            req_ack  <= grant;
            cmd      <= '{op:   req_op[win_idx],
                          addr: req_addr[sel*ADDR_W +: ADDR_W],
                          din:  req_din[sel*DATA_W +: DATA_W]};
            id_q     <= win_idx;
            cnt      <= '0;
            err_q    <= 1'b0;
            retried  <= 1'b0;
            m_newd   <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= CNT_W'(1);
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          err_q <= done_err;
          if (m_done) begin
            if (retry_now) begin
              retried <= 1'b1;
              err_q   <= 1'b0;
              cnt     <= '0;
              m_newd  <= 1'b1;
              state   <= ISSUE;
            end else begin
              rsp_valid   <= 1'b1;
              rsp_id      <= id_q;
              rsp_dout    <= cmd.op ? m_dout : '0;
              rsp_err     <= done_err;
              rsp_timeout <= 1'b0;
              state       <= RESP;
            end
          end else if (cnt == CNT_W'(TIMEOUT-1)) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= id_q;
            rsp_dout    <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          ptr   <= (id_q == ID_W'(NREQ-1)) ? '0 : id_q + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed self-checking bench for i2c_req_arbiter with a simple behavioural I2C master.
module tb_i2c_req_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int MLAT    = 6;
`ifdef I2C_ARB_RETRY_EN
  localparam int EXP_ERR_NEWD = 2;
`else
  localparam int EXP_ERR_NEWD = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  req_op = '0;
  logic [27:0] req_addr = '0;
  logic [31:0] req_din = '0;
  logic [3:0]  req_ack;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_dout;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        m_newd;
  logic        m_op;
  logic [6:0]  m_addr;
  logic [7:0]  m_din;
  logic [7:0]  m_dout = '0;
  logic        m_busy = 1'b0;
  logic        m_ack_err = 1'b0;
  logic        m_done = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int newd_cnt = 0;
  int busy_viol = 0;
  bit suppress_done = 1'b0;
  logic [7:0] slave_data = 8'h3C;
  int mcnt = 0;
  logic cur_op = 1'b0;
  logic [6:0] cur_addr = '0;

  i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_addr(req_addr), .req_din(req_din),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_dout(rsp_dout),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .m_newd(m_newd), .m_op(m_op),
    .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout), .m_busy(m_busy),
    .m_ack_err(m_ack_err), .m_done(m_done)
  );

  always #5 clk = ~clk;

  // Master model: busy for MLAT cycles after newd, then one done pulse; 7'h7F is never acked.
  always @(negedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_ack_err = 1'b0; m_dout = '0; mcnt = 0;
    end else begin
      m_done = 1'b0;
      m_ack_err = 1'b0;
      if (m_newd) begin
        newd_cnt++;
        if (m_busy) busy_viol++;
        m_busy = 1'b1; mcnt = MLAT; cur_op = m_op; cur_addr = m_addr;
      end else if (m_busy) begin
        if (mcnt > 1) mcnt--;
        else begin
          m_busy = 1'b0;
          if (!suppress_done) begin
            m_done = 1'b1;
            m_dout = cur_op ? slave_data : 8'h00;
            m_ack_err = (cur_addr == 7'h7F);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic set_req(input int i, input logic op, input logic [6:0] a, input logic [7:0] d);
    req_op[i] = op;
    req_addr[7*i +: 7] = a;
    req_din[8*i +: 8] = d;
    req[i] = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    n_checks++;
    if ({req_ack, rsp_valid, m_newd} !== 6'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 0", {req_ack, rsp_valid, m_newd});
    end
    n_checks++;
    if ({rsp_id, rsp_dout, rsp_err, rsp_timeout, m_op, m_addr, m_din} !== 28'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0",
                         {rsp_id, rsp_dout, rsp_err, rsp_timeout, m_op, m_addr, m_din});
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single_write;
    bit ok;
    set_req(1, 1'b0, 7'h2A, 8'hA5);
    tick(1);
    n_checks++;
    if ({req_ack, m_newd} !== 5'b0010_1) begin
      n_fail++; $display("FAIL write_ack: got %b want 00101", {req_ack, m_newd});
    end
    req = '0;
    tick(1);
    n_checks++;
    if ({req_ack, m_newd, m_op, m_addr, m_din} !== {4'b0, 1'b0, 1'b0, 7'h2A, 8'hA5}) begin
      n_fail++; $display("FAIL write_drive: got %h want %h", {req_ack, m_newd, m_op, m_addr, m_din},
                         {4'b0, 1'b0, 1'b0, 7'h2A, 8'hA5});
    end
    wait_rsp(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL write_rsp_seen: got none want rsp_valid"); end
    n_checks++;
    if ({rsp_id, rsp_err, rsp_timeout, rsp_dout} !== {2'd1, 1'b0, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL write_rsp: got %h want %h", {rsp_id, rsp_err, rsp_timeout, rsp_dout},
                         {2'd1, 1'b0, 1'b0, 8'h00});
    end
    tick(1);
    n_checks++;
    if ({rsp_valid, rsp_id} !== {1'b0, 2'd1}) begin
      n_fail++; $display("FAIL write_rsp_hold: got %b want 001", {rsp_valid, rsp_id});
    end
  endtask

  task automatic test_single_read;
    bit ok;
    slave_data = 8'h3C;
    set_req(2, 1'b1, 7'h50, 8'h00);
    tick(1);
    n_checks++;
    if (req_ack !== 4'b0100) begin
      n_fail++; $display("FAIL read_ack: got %b want 0100", req_ack);
    end
    req = '0;
    wait_rsp(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL read_rsp_seen: got none want rsp_valid"); end
    n_checks++;
    if ({rsp_id, rsp_err, rsp_timeout, rsp_dout} !== {2'd2, 1'b0, 1'b0, 8'h3C}) begin
      n_fail++; $display("FAIL read_rsp: got %h want %h", {rsp_id, rsp_err, rsp_timeout, rsp_dout},
                         {2'd2, 1'b0, 1'b0, 8'h3C});
    end
    tick(1);
  endtask

  task automatic test_round_robin;
    bit ok;
    int base;
    logic [1:0] ids [5];
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    base = newd_cnt;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 7'(7'h10 + i), 8'(8'h80 + i));
    for (int k = 0; k < 5; k++) begin
      wait_rsp(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rr_rsp_seen_%0d: got none want rsp_valid", k); end
      ids[k] = rsp_id;
      if (k == 4) req = '0;
    end
    tick(3);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (ids[k] !== 2'(k % 4)) begin
        n_fail++; $display("FAIL rr_order_%0d: got %0d want %0d", k, ids[k], k % 4);
      end
    end
    n_checks++;
    if (newd_cnt - base !== 5) begin
      n_fail++; $display("FAIL rr_newd_count: got %0d want 5", newd_cnt - base);
    end
    n_checks++;
    if (busy_viol !== 0) begin
      n_fail++; $display("FAIL rr_newd_while_busy: got %0d want 0", busy_viol);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    bit seen;
    int n;
    suppress_done = 1'b1;
    set_req(0, 1'b1, 7'h11, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_newd) begin seen = 1'b1; break; end
    end
    req = '0;
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL to_newd_seen: got none want m_newd"); end
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok || n !== TIMEOUT) begin
      n_fail++; $display("FAIL to_latency: got %0d cycles (seen=%0d) want %0d", n, ok, TIMEOUT);
    end
    n_checks++;
    if ({rsp_id, rsp_err, rsp_timeout, rsp_dout} !== {2'd0, 1'b1, 1'b1, 8'h00}) begin
      n_fail++; $display("FAIL to_rsp: got %h want %h", {rsp_id, rsp_err, rsp_timeout, rsp_dout},
                         {2'd0, 1'b1, 1'b1, 8'h00});
    end
    suppress_done = 1'b0;
    tick(MLAT);
    set_req(1, 1'b0, 7'h22, 8'h5A);
    tick(1);
    req = '0;
    wait_rsp(ok);
    n_checks++;
    if (!ok || {rsp_id, rsp_err, rsp_timeout} !== {2'd1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL to_next: got seen=%0d %b want seen=1 0100", ok,
                         {rsp_id, rsp_err, rsp_timeout});
    end
    tick(1);
  endtask

  task automatic test_ack_error;
    bit ok;
    int base;
    base = newd_cnt;
    set_req(2, 1'b0, 7'h7F, 8'h33);
    tick(1);
    req = '0;
    wait_rsp(ok);
    n_checks++;
    if (!ok || {rsp_id, rsp_err, rsp_timeout} !== {2'd2, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL ackerr_rsp: got seen=%0d %b want seen=1 1010", ok,
                         {rsp_id, rsp_err, rsp_timeout});
    end
    n_checks++;
    if (newd_cnt - base !== EXP_ERR_NEWD) begin
      n_fail++; $display("FAIL ackerr_newd_count: got %0d want %0d", newd_cnt - base, EXP_ERR_NEWD);
    end
    tick(1);
  endtask

  task automatic test_reset_mid;
    bit ok;
    int stray;
    set_req(1, 1'b0, 7'h33, 8'h44);
    tick(1);
    n_checks++;
    if (req_ack !== 4'b0010) begin
      n_fail++; $display("FAIL mid_ack: got %b want 0010", req_ack);
    end
    req = '0;
    tick(2);
    rst = 1'b1;
    tick(1);
    n_checks++;
    if ({req_ack, rsp_valid, m_newd, m_op, m_addr, m_din} !== 22'h0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h want 0",
                         {req_ack, rsp_valid, m_newd, m_op, m_addr, m_din});
    end
    tick(1);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) stray++;
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++; $display("FAIL mid_no_rsp: got %0d rsp_valid pulses want 0", stray);
    end
    set_req(3, 1'b1, 7'h44, 8'h00);
    tick(1);
    n_checks++;
    if (req_ack !== 4'b1000) begin
      n_fail++; $display("FAIL mid_fresh_ack: got %b want 1000", req_ack);
    end
    req = '0;
    wait_rsp(ok);
    n_checks++;
    if (!ok || {rsp_id, rsp_err} !== {2'd3, 1'b0}) begin
      n_fail++; $display("FAIL mid_fresh_rsp: got seen=%0d %b want seen=1 110", ok, {rsp_id, rsp_err});
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_ack_error();
    test_reset_mid();
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
